// File: rtl/controle_pkg.sv
// Shared encodings for the multicycle control sequencer and its decoder.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package controle_pkg;

    // ATUALIZA_PC must match the code the PC-update stage watches for.
    localparam logic [3:0] EST_BUSCA       = 4'b0001;
    localparam logic [3:0] EST_DECODIFICA  = 4'b0010;
    localparam logic [3:0] EST_EXECUTA     = 4'b0011;
    localparam logic [3:0] EST_MEMORIA     = 4'b0100;
    localparam logic [3:0] EST_ESCRITA     = 4'b0101;
    localparam logic [3:0] EST_ATUALIZA_PC = 4'b1000;

    typedef enum logic [3:0] {
        BUSCA       = EST_BUSCA,
        DECODIFICA  = EST_DECODIFICA,
        EXECUTA     = EST_EXECUTA,
        MEMORIA     = EST_MEMORIA,
        ESCRITA     = EST_ESCRITA,
        ATUALIZA_PC = EST_ATUALIZA_PC
    } estado_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [1:0] ALUOP_SOMA  = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Exactly one field is set for any instruction word.
    typedef struct packed {
        logic r;
        logic i_alu;
        logic lw;
        logic sw;
        logic beq;
        logic bne;
        logic inval;
    } classe_t;

endpackage

// File: rtl/unidade_controle_decodificador.sv
// Classifies the latched instruction into a one-hot class.
// Latency: purely combinational.
// Backpressure: none.
import controle_pkg::*;

module decodificador (
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    output logic [6:0] classe
);

    classe_t cls;

    always_comb begin
        cls = '0;
        case (opcode)
            OP_R:      cls.r     = 1'b1;
            OP_I_ALU:  cls.i_alu = 1'b1;
            OP_LW:     cls.lw    = 1'b1;
            OP_SW:     cls.sw    = 1'b1;
            OP_BRANCH: begin
                if (funct3 == F3_BEQ)      cls.beq   = 1'b1;
                else if (funct3 == F3_BNE) cls.bne   = 1'b1;
                else                       cls.inval = 1'b1;
            end
            default:   cls.inval = 1'b1;
        endcase
    end

    assign classe = cls;

endmodule

// File: rtl/unidade_controle.sv
// Multicycle RISC-V control sequencer: IR latch, state walk, datapath strobes.
// Latency: 3..6 cycles per instruction, one cycle per state.
// Backpressure: none; every state lasts exactly one cycle.
import controle_pkg::*;

module unidade_controle (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instrucao,
    input  logic        zero,
    output logic [3:0]  estado,
    output logic        pcsrc,
    output logic        negativo,
    output logic [31:0] ir,
    output logic        regwrite,
    output logic        memread,
    output logic        memwrite,
    output logic        alusrc,
    output logic        memtoreg,
    output logic [1:0]  aluop,
    output logic        invalida
);

    estado_t     estado_q;
    estado_t     estado_prox;
    logic [31:0] ir_q;
    logic        pcsrc_q;
    logic        negativo_q;
    logic [6:0]  classe_vec;
    classe_t     classe;

    decodificador u_decodificador (
        .opcode (ir_q[6:0]),
        .funct3 (ir_q[14:12]),
        .classe (classe_vec)
    );

    assign classe = classe_t'(classe_vec);

    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q   <= BUSCA;
            ir_q       <= '0;
            pcsrc_q    <= 1'b0;
            negativo_q <= 1'b0;
        end else begin
            estado_q <= estado_prox;
            case (estado_q)
                BUSCA: begin
                    // Branch outcome stays visible through ATUALIZA_PC, clears here.
                    ir_q       <= instrucao;
                    pcsrc_q    <= 1'b0;
                    negativo_q <= 1'b0;
                end
                DECODIFICA: begin
                    if (classe.inval) pcsrc_q <= 1'b0;
                end
                EXECUTA: begin
                    if (classe.beq || classe.bne) begin
                        pcsrc_q    <= classe.beq ? zero : !zero;
                        negativo_q <= ir_q[31];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        estado_prox = BUSCA;
        regwrite    = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        alusrc      = 1'b0;
        memtoreg    = 1'b0;
        aluop       = ALUOP_SOMA;
        invalida    = 1'b0;
        case (estado_q)
            BUSCA:      estado_prox = DECODIFICA;
            DECODIFICA: estado_prox = classe.inval ? ATUALIZA_PC : EXECUTA;
            EXECUTA: begin
                alusrc = classe.i_alu | classe.lw | classe.sw;
                if (classe.r || classe.i_alu) begin
                    estado_prox = ESCRITA;
                    aluop       = ALUOP_FUNCT;
                end else if (classe.lw || classe.sw) begin
                    estado_prox = MEMORIA;
                    aluop       = ALUOP_SOMA;
                end else if (classe.beq || classe.bne) begin
                    estado_prox = ATUALIZA_PC;
                    aluop       = ALUOP_SUB;
                end else begin
                    estado_prox = ATUALIZA_PC;
                end
            end
            MEMORIA: begin
                estado_prox = classe.lw ? ESCRITA : ATUALIZA_PC;
                memread     = classe.lw;
                memwrite    = classe.sw;
            end
            ESCRITA: begin
                estado_prox = ATUALIZA_PC;
                regwrite    = classe.r | classe.i_alu | classe.lw;
                memtoreg    = classe.lw;
            end
            ATUALIZA_PC: begin
                estado_prox = BUSCA;
                invalida    = classe.inval;
            end
            default:    estado_prox = BUSCA;
        endcase
    end

    assign estado   = estado_q;
    assign ir       = ir_q;
    assign pcsrc    = pcsrc_q;
    assign negativo = negativo_q;

endmodule

// File: tb/tb_unidade_controle.sv
// Randomized bench for unidade_controle against a per-instruction cycle-table model.
module tb_unidade_controle;

    logic        clk = 1'b0;
    logic        rst;
    logic        zero;
    logic [31:0] instrucao;
    logic [3:0]  estado;
    logic        pcsrc;
    logic        negativo;
    logic [31:0] ir;
    logic        regwrite, memread, memwrite, alusrc, memtoreg;
    logic [1:0]  aluop;
    logic        invalida;

    always #5 clk = ~clk;

    unidade_controle dut (
        .clk       (clk),
        .rst       (rst),
        .instrucao (instrucao),
        .zero      (zero),
        .estado    (estado),
        .pcsrc     (pcsrc),
        .negativo  (negativo),
        .ir        (ir),
        .regwrite  (regwrite),
        .memread   (memread),
        .memwrite  (memwrite),
        .alusrc    (alusrc),
        .memtoreg  (memtoreg),
        .aluop     (aluop),
        .invalida  (invalida)
    );

    typedef struct packed {
        logic [3:0]  estado;
        logic        pcsrc;
        logic        negativo;
        logic [31:0] ir;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        alusrc;
        logic        memtoreg;
        logic [1:0]  aluop;
        logic        invalida;
    } obs_t;

    localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BR = 4, K_INV = 5;

    obs_t        exp_o;
    obs_t        exp_seq [8];
    obs_t        rr;
    int          exp_len;
    logic        chk_en = 1'b0;
    int          errors = 0;
    int          checks = 0;

    logic [31:0] lit_got  [64];
    logic [31:0] lit_want [64];
    string       lit_nm   [64];
    int          lit_n = 0;
    int          lit_done = 0;

    // Architectural values carried from one instruction into the next BUSCA cycle.
    logic [31:0] m_ir;
    logic        m_pc, m_neg;

    logic [31:0] tr_st;
    logic [7:0]  tr_rw, tr_mr, tr_mw, tr_mtr, tr_pc, tr_neg, tr_inv;
    logic [15:0] tr_alu;

    always @(negedge clk) begin
        obs_t got;
        got = {estado, pcsrc, negativo, ir, regwrite, memread, memwrite,
               alusrc, memtoreg, aluop, invalida};
        if (chk_en) begin
            checks++;
            if (got !== exp_o) begin
                errors++;
                $display("FAIL cycle t=%0t got est=%h pc=%b neg=%b ir=%h rw=%b mr=%b mw=%b as=%b mtr=%b op=%b inv=%b | want est=%h pc=%b neg=%b ir=%h rw=%b mr=%b mw=%b as=%b mtr=%b op=%b inv=%b",
                         $time, got.estado, got.pcsrc, got.negativo, got.ir, got.regwrite,
                         got.memread, got.memwrite, got.alusrc, got.memtoreg, got.aluop, got.invalida,
                         exp_o.estado, exp_o.pcsrc, exp_o.negativo, exp_o.ir, exp_o.regwrite,
                         exp_o.memread, exp_o.memwrite, exp_o.alusrc, exp_o.memtoreg, exp_o.aluop,
                         exp_o.invalida);
            end
        end
        while (lit_done < lit_n) begin
            checks++;
            if (lit_got[lit_done] !== lit_want[lit_done]) begin
                errors++;
                $display("FAIL %s got=%h want=%h", lit_nm[lit_done],
                         lit_got[lit_done], lit_want[lit_done]);
            end
            lit_done++;
        end
    end

    task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] want);
        if (lit_n < 64) begin
            lit_nm[lit_n]   = nm;
            lit_got[lit_n]  = got;
            lit_want[lit_n] = want;
            lit_n++;
        end
    endtask

    // Expected outputs for every cycle of one instruction, from BUSCA to ATUALIZA_PC.
    task automatic build(input logic [31:0] ins, input logic z);
        int         kind;
        logic [3:0] st [6];
        logic       taken;
        obs_t       r;
        case (ins[6:0])
            7'b0110011: kind = K_R;
            7'b0010011: kind = K_I;
            7'b0000011: kind = K_LW;
            7'b0100011: kind = K_SW;
            7'b1100011: kind = (ins[14:12] <= 3'b001) ? K_BR : K_INV;
            default:    kind = K_INV;
        endcase
        taken = (ins[14:12] == 3'b000) ? z : !z;
        case (kind)
            K_R, K_I: begin st = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h8, 4'h0}; exp_len = 5; end
            K_LW:     begin st = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8}; exp_len = 6; end
            K_SW:     begin st = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h0}; exp_len = 5; end
            K_BR:     begin st = '{4'h1, 4'h2, 4'h3, 4'h8, 4'h0, 4'h0}; exp_len = 4; end
            default:  begin st = '{4'h1, 4'h2, 4'h8, 4'h0, 4'h0, 4'h0}; exp_len = 3; end
        endcase
        for (int k = 0; k < exp_len; k++) begin
            r          = '0;
            r.estado   = st[k];
            r.ir       = (k == 0) ? m_ir  : ins;
            r.pcsrc    = (k == 0) ? m_pc  : 1'b0;
            r.negativo = (k == 0) ? m_neg : 1'b0;
            if (st[k] == 4'h3) begin
                r.aluop  = (kind == K_R || kind == K_I) ? 2'b10 : (kind == K_BR) ? 2'b01 : 2'b00;
                r.alusrc = (kind == K_I || kind == K_LW || kind == K_SW);
            end
            if (st[k] == 4'h4) begin
                r.memread  = (kind == K_LW);
                r.memwrite = (kind == K_SW);
            end
            if (st[k] == 4'h5) begin
                r.regwrite = 1'b1;
                r.memtoreg = (kind == K_LW);
            end
            if (st[k] == 4'h8) begin
                r.invalida = (kind == K_INV);
                if (kind == K_BR) begin
                    r.pcsrc    = taken;
                    r.negativo = ins[31];
                end
            end
            exp_seq[k] = r;
        end
    endtask

    task automatic step(input logic [31:0] ins, input logic z, input logic r, input obs_t e);
        @(posedge clk);
        #1;
        instrucao = ins;
        zero      = z;
        rst       = r;
        exp_o     = e;
        chk_en    = 1'b1;
        tr_st  = {tr_st[27:0], estado};
        tr_rw  = {tr_rw[6:0], regwrite};
        tr_mr  = {tr_mr[6:0], memread};
        tr_mw  = {tr_mw[6:0], memwrite};
        tr_mtr = {tr_mtr[6:0], memtoreg};
        tr_pc  = {tr_pc[6:0], pcsrc};
        tr_neg = {tr_neg[6:0], negativo};
        tr_inv = {tr_inv[6:0], invalida};
        tr_alu = {tr_alu[13:0], aluop};
    endtask

    // abort_at >= 0 raises rst during that cycle of the instruction and holds it one more.
    task automatic run_instr(input logic [31:0] ins, input logic z, input int abort_at);
        logic [31:0] iv;
        logic        zv;
        build(ins, z);
        tr_st = '0; tr_rw = '0; tr_mr = '0; tr_mw = '0; tr_mtr = '0;
        tr_pc = '0; tr_neg = '0; tr_inv = '0; tr_alu = '0;
        for (int k = 0; k < exp_len; k++) begin
            iv = (k == 0) ? ins : $urandom;
            zv = (exp_seq[k].estado == 4'h3) ? z : 1'($urandom);
            step(iv, zv, (k == abort_at), exp_seq[k]);
            if (k == abort_at) begin
                step($urandom, 1'($urandom), 1'b1, rr);
                m_ir  = '0;
                m_pc  = 1'b0;
                m_neg = 1'b0;
                return;
            end
        end
        m_ir  = ins;
        m_pc  = exp_seq[exp_len-1].pcsrc;
        m_neg = exp_seq[exp_len-1].negativo;
    endtask

    initial begin
        logic [31:0] ins;
        int          kind;
        int          ab;
        rst       = 1'b1;
        zero      = 1'b0;
        instrucao = '0;
        m_ir      = '0;
        m_pc      = 1'b0;
        m_neg     = 1'b0;
        rr        = '0;
        rr.estado = 4'h1;

        step($urandom, 1'($urandom), 1'b1, rr);
        step($urandom, 1'($urandom), 1'b1, rr);
        lit("reset_estado", 32'(estado), 32'h1);
        lit("reset_pcsrc", 32'(pcsrc), 32'h0);

        run_instr(32'h002081B3, 1'b0, -1);
        lit("add_states", 32'(tr_st[19:0]), 32'h12358);
        lit("add_regwrite", 32'(tr_rw[4:0]), 32'b00010);
        lit("add_aluop", 32'(tr_alu[9:0]), 32'b00_00_10_00_00);
        lit("add_pcsrc", 32'(tr_pc[4:0]), 32'h0);

        run_instr(32'h0000A103, 1'b0, -1);
        lit("lw_states", 32'(tr_st[23:0]), 32'h123458);
        lit("lw_memread", 32'(tr_mr[5:0]), 32'b000100);
        lit("lw_memtoreg", 32'(tr_mtr[5:0]), 32'b000010);
        lit("lw_regwrite", 32'(tr_rw[5:0]), 32'b000010);

        run_instr(32'h0020A023, 1'b0, -1);
        lit("sw_states", 32'(tr_st[19:0]), 32'h12348);
        lit("sw_memwrite", 32'(tr_mw[4:0]), 32'b00010);
        lit("sw_regwrite", 32'(tr_rw[4:0]), 32'h0);

        run_instr(32'hFE000EE3, 1'b1, -1);
        lit("beq_taken_states", 32'(tr_st[15:0]), 32'h1238);
        lit("beq_taken_pcsrc", 32'(tr_pc[3:0]), 32'b0001);
        lit("beq_taken_neg", 32'(tr_neg[3:0]), 32'b0001);

        run_instr(32'hFE000EE3, 1'b0, -1);
        lit("beq_nt_pcsrc", 32'(tr_pc[3:0]), 32'b1000);
        lit("beq_nt_neg", 32'(tr_neg[3:0]), 32'b1001);

        run_instr(32'h0000007F, 1'b0, -1);
        lit("inv_states", 32'(tr_st[11:0]), 32'h128);
        lit("inv_pulse", 32'(tr_inv[2:0]), 32'b001);
        lit("inv_pcsrc", 32'(tr_pc[2:0]), 32'h0);
        lit("inv_strobes", 32'({tr_rw[2:0], tr_mr[2:0], tr_mw[2:0], tr_mtr[2:0]}), 32'h0);

        run_instr(32'h0000A103, 1'b0, 3);
        lit("lw_abort_states", 32'(tr_st[19:0]), 32'h12341);
        lit("lw_abort_regwrite", 32'(tr_rw[4:0]), 32'h0);

        for (int n = 0; n < 400; n++) begin
            ins  = $urandom;
            kind = $urandom_range(0, 7);
            case (kind)
                0: ins[6:0] = 7'b0110011;
                1: ins[6:0] = 7'b0010011;
                2: ins[6:0] = 7'b0000011;
                3: ins[6:0] = 7'b0100011;
                4: begin ins[6:0] = 7'b1100011; ins[14:12] = 3'b000; end
                5: begin ins[6:0] = 7'b1100011; ins[14:12] = 3'b001; end
                6: begin ins[6:0] = 7'b1100011; ins[14:12] = 3'($urandom_range(2, 7)); end
                default: ;
            endcase
            ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 5)) : -1;
            run_instr(ins, 1'($urandom), ab);
        end

        @(posedge clk);
        #1;
        chk_en = 1'b0;
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
